mux_router: RTL and testbench

MUX_ROUTER -- requirements
Module: mux_router

---
 rtl/lock_pkg.sv | 17 +
 rtl/mux_router_ch.sv | 128 ++++++++++++
 rtl/mux_router.sv | 42 ++++
 tb/tb_mux_router.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared channel state encoding and width helper for mux_router
package lock_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BLANK = 1'b1
   } ch_state_t;

   // Smallest w with 2**w >= n; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mux_router_ch.sv
// rtl/mux_router_ch.sv - one output channel: select FSM, blank counter, source mux, output register
// Blanking compiled in only when MUX_ROUTER_BLANK_EN is defined.
module mux_router_ch
   import lock_pkg::*;
#(
   parameter int RES     = 14,
   parameter int NIN     = 16,
   parameter int SELW    = 4,
   parameter int BLANK_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NIN*RES-1:0]   i_in_bus,
   input  logic [SELW-1:0]      i_sel,
   input  logic                 i_sel_we,
   input  logic [BLANK_W-1:0]   i_blank_len,
   output logic [RES-1:0]       o_out,
   output logic [SELW-1:0]      o_sel_act,
   output logic                 o_busy
);

   // Out-of-range selects fall through the loop and route constant 0.
   function automatic logic [RES-1:0] route(input logic [NIN*RES-1:0] bus,
                                            input logic [SELW-1:0]    idx);
      logic [RES-1:0] v;
      v = '0;
      for (int k = 0; k < NIN; k++)
         if (int'(idx) == k) v = bus[k*RES +: RES];
      return v;
   endfunction

   logic [RES-1:0]  r_out;
   logic [SELW-1:0] r_sel_act;
   logic [RES-1:0]  w_mux_act;
   logic [RES-1:0]  w_mux_new;

   assign w_mux_act = route(i_in_bus, r_sel_act);
   assign w_mux_new = route(i_in_bus, i_sel);
   assign o_out     = r_out;
   assign o_sel_act = r_sel_act;

`ifdef MUX_ROUTER_BLANK_EN
   localparam logic [BLANK_W-1:0] CNT_ONE = 1;

   ch_state_t        r_state;
   logic [BLANK_W-1:0] r_cnt;
   logic [SELW-1:0]  r_pend;
   logic             r_busy;
   logic [RES-1:0]   w_mux_pend;

   assign w_mux_pend = route(i_in_bus, r_pend);
   assign o_busy     = r_busy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pend    <= '0;
         r_busy    <= 1'b0;
         r_sel_act <= '0;
         r_out     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_sel_we && (i_sel != r_sel_act)) begin
                  if (i_blank_len != '0) begin
                     r_state <= ST_BLANK;
                     r_pend  <= i_sel;
                     r_cnt   <= i_blank_len;
                     r_busy  <= 1'b1;
                     r_out   <= '0;
                  end else begin
                     r_sel_act <= i_sel;
                     r_out     <= w_mux_new;
                  end
               end else begin
                  r_out <= w_mux_act;
               end
            end
            ST_BLANK: begin
               // A new strobe replaces the pending select and restarts the count.
               if (i_sel_we) begin
                  if (i_blank_len != '0) begin
                     r_pend <= i_sel;
                     r_cnt  <= i_blank_len;
                     r_out  <= '0;
                  end else begin
                     r_state   <= ST_IDLE;
                     r_cnt     <= '0;
                     r_busy    <= 1'b0;
                     r_sel_act <= i_sel;
                     r_out     <= w_mux_new;
                  end
               end else if (r_cnt == CNT_ONE) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_busy    <= 1'b0;
                  r_sel_act <= r_pend;
                  r_out     <= w_mux_pend;
               end else begin
                  r_cnt <= r_cnt - CNT_ONE;
                  r_out <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
`else
   logic w_unused_blank;

   assign w_unused_blank = ^i_blank_len;
   assign o_busy         = 1'b0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sel_act <= '0;
         r_out     <= '0;
      end else if (i_sel_we && (i_sel != r_sel_act)) begin
         r_sel_act <= i_sel;
         r_out     <= w_mux_new;
      end else begin
         r_out <= w_mux_act;
      end
   end
`endif

endmodule

// File: rtl/mux_router.sv
// rtl/mux_router.sv - NOUT independent registered selectors over NIN inputs with optional switch blanking
// Blanking compiled in only when MUX_ROUTER_BLANK_EN is defined.
module mux_router
   import lock_pkg::*;
#(
   parameter  int RES     = 14,
   parameter  int NIN     = 16,
   parameter  int NOUT    = 4,
   parameter  int BLANK_W = 8,
   localparam int SELW    = clog2(NIN)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NIN*RES-1:0]     in_bus,
   input  logic [NOUT*SELW-1:0]   sel,
   input  logic [NOUT-1:0]        sel_we,
   input  logic [BLANK_W-1:0]     blank_len,
   output logic [NOUT*RES-1:0]    out_bus,
   output logic [NOUT*SELW-1:0]   sel_act,
   output logic [NOUT-1:0]        busy
);

   for (genvar j = 0; j < NOUT; j++) begin : g_ch
      mux_router_ch #(
         .RES     (RES),
         .NIN     (NIN),
         .SELW    (SELW),
         .BLANK_W (BLANK_W)
      ) u_ch (
         .i_clk       (clk),
         .i_rst       (rst),
         .i_in_bus    (in_bus),
         .i_sel       (sel[j*SELW +: SELW]),
         .i_sel_we    (sel_we[j]),
         .i_blank_len (blank_len),
         .o_out       (out_bus[j*RES +: RES]),
         .o_sel_act   (sel_act[j*SELW +: SELW]),
         .o_busy      (busy[j])
      );
   end

endmodule

// File: tb/tb_mux_router.sv
// tb/tb_mux_router.sv - directed self-checking bench for mux_router (NIN=12, NOUT=2)
module tb_mux_router;

`ifdef MUX_ROUTER_BLANK_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   localparam int RES     = 14;
   localparam int NIN     = 12;
   localparam int NOUT    = 2;
   localparam int BLANK_W = 8;
   localparam int SELW    = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NIN*RES-1:0]    in_bus;
   logic [NOUT*SELW-1:0]  sel;
   logic [NOUT-1:0]       sel_we;
   logic [BLANK_W-1:0]    blank_len;
   logic [NOUT*RES-1:0]   out_bus;
   logic [NOUT*SELW-1:0]  sel_act;
   logic [NOUT-1:0]       busy;

   logic [31:0] o0, o1, sa0, sa1, b0, ob_all, sa_all, b_all;

   int checks = 0;
   int errors = 0;

   mux_router #(
      .RES     (RES),
      .NIN     (NIN),
      .NOUT    (NOUT),
      .BLANK_W (BLANK_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_bus    (in_bus),
      .sel       (sel),
      .sel_we    (sel_we),
      .blank_len (blank_len),
      .out_bus   (out_bus),
      .sel_act   (sel_act),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   assign o0     = {18'd0, out_bus[13:0]};
   assign o1     = {18'd0, out_bus[27:14]};
   assign sa0    = {28'd0, sel_act[3:0]};
   assign sa1    = {28'd0, sel_act[7:4]};
   assign b0     = {31'd0, busy[0]};
   assign ob_all = {4'd0, out_bus};
   assign sa_all = {24'd0, sel_act};
   assign b_all  = {30'd0, busy};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      // Input 3 carries 100, every other input k carries 1000+k.
      for (int k = 0; k < NIN; k++)
         in_bus[k*RES +: RES] = (k == 3) ? 14'd100 : 14'(1000 + k);
      rst       = 1'b1;
      sel       = '0;
      sel_we    = '0;
      blank_len = '0;
      tick();
      tick();
      chk("rst_out", ob_all, 0);
      chk("rst_busy", b_all, 0);
      chk("rst_sel_act", sa_all, 0);

      sel[3:0] = 4'd3;
      sel_we   = 2'b01;
      tick();
      sel_we   = 2'b00;
      chk("we_in_rst", sa0, 0);

      rst = 1'b0;
      tick();
      chk("idle_in0", o0, 1000);

      sel[3:0] = 4'd3;
      sel_we   = 2'b01;
      tick();
      sel_we   = 2'b00;
      chk("sel3_act", sa0, 3);
      chk("sel3_out", o0, 100);

      blank_len = 8'd4;
      sel_we    = 2'b01;
      tick();
      sel_we    = 2'b00;
      chk("same_sel_busy", b0, 0);
      chk("same_sel_out", o0, 100);

      sel[3:0] = 4'd5;
      sel_we   = 2'b01;
      tick();
      sel_we    = 2'b00;
      blank_len = 8'd1;
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("blank_out_t%0d", i), o0, BLANK_EN ? 0 : 1005);
         chk($sformatf("blank_busy_t%0d", i), b0, BLANK_EN ? 1 : 0);
         chk($sformatf("blank_act_t%0d", i), sa0, BLANK_EN ? 3 : 5);
         tick();
      end
      chk("blank_end_out", o0, 1005);
      chk("blank_end_act", sa0, 5);
      chk("blank_end_busy", b0, 0);

      blank_len = 8'd0;
      sel[3:0]  = 4'd3;
      sel_we    = 2'b01;
      tick();
      sel_we    = 2'b00;
      chk("back3_act", sa0, 3);

      blank_len = 8'd4;
      sel[3:0]  = 4'd5;
      sel_we    = 2'b01;
      tick();
      sel_we    = 2'b00;
      chk("rs_out_t1", o0, BLANK_EN ? 0 : 1005);
      tick();
      chk("rs_out_t2", o0, BLANK_EN ? 0 : 1005);
      sel[3:0] = 4'd7;
      sel_we   = 2'b01;
      tick();
      sel_we   = 2'b00;
      for (int i = 3; i <= 6; i++) begin
         chk($sformatf("rs_out_t%0d", i), o0, BLANK_EN ? 0 : 1007);
         chk($sformatf("rs_busy_t%0d", i), b0, BLANK_EN ? 1 : 0);
         chk($sformatf("rs_act_t%0d", i), sa0, BLANK_EN ? 3 : 7);
         tick();
      end
      chk("rs_end_out", o0, 1007);
      chk("rs_end_act", sa0, 7);

      blank_len = 8'd0;
      sel[3:0]  = 4'd2;
      sel_we    = 2'b01;
      tick();
      sel[3:0]  = 4'd9;
      tick();
      sel_we    = 2'b00;
      chk("nb_out", o0, 1009);
      chk("nb_busy", b0, 0);
      chk("nb_act", sa0, 9);

      sel[7:4] = 4'd9;
      sel_we   = 2'b10;
      tick();
      sel_we   = 2'b00;
      chk("share_out1", o1, 1009);
      chk("share_out0", o0, 1009);

      sel[7:4] = 4'd14;
      sel_we   = 2'b10;
      tick();
      sel_we   = 2'b00;
      chk("oor_out1", o1, 0);
      chk("oor_act1", sa1, 14);
      chk("oor_out0", o0, 1009);

      blank_len = 8'd6;
      sel[3:0]  = 4'd4;
      sel_we    = 2'b01;
      tick();
      sel_we    = 2'b00;
      chk("abort_out_t1", o0, BLANK_EN ? 0 : 1004);
      tick();
      rst = 1'b1;
      tick();
      chk("abort_out", ob_all, 0);
      chk("abort_busy", b_all, 0);
      chk("abort_act", sa_all, 0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("post_abort_act_%0d", i), sa0, 0);
         chk($sformatf("post_abort_out_%0d", i), o0, 1000);
         chk($sformatf("post_abort_busy_%0d", i), b0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
